// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_arb_pkg
//  Description : Shared definitions for the AXI-Stream round-robin arbiter:
//                FSM state encoding and the round-robin winner function.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  // Upper bound on channel count; the winner function works on this width.
  localparam int c_max_ch = 16;

  // Arbiter FSM state encoding
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t c_st_idle   = 1'b0;
  localparam arb_state_t c_st_stream = 1'b1;

  // First requesting channel found scanning upward from (last_grant+1) with
  // wrap at num_ch. Returns 0 when nothing requests (caller ignores it then).
  function automatic logic [3:0] next_rr(
    input logic [c_max_ch-1:0] req,
    input logic [3:0]          last_grant,
    input int                  num_ch
  );
    logic [3:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= c_max_ch; k++) begin
      idx = (int'(last_grant) + k) % num_ch;
      if (!found && (k <= num_ch) && req[idx]) begin
        win   = 4'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry skid buffer with a registered input ready, so the
//                downstream ready never reaches the upstream ready
//                combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer
  import axis_arb_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 35
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);

  logic [PAYLOAD_WIDTH-1:0] r_head;
  logic [PAYLOAD_WIDTH-1:0] r_tail;
  logic [1:0]               r_occ;
  logic                     r_in_ready;
  logic                     w_push;
  logic                     w_pop;
  logic [1:0]               w_occ_next;

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_occ != 2'd0);
  assign out_payload = r_head;
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = out_valid & out_ready;

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_occ_next = r_occ + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Storage update; full buffer never sees a push because in_ready is low
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_in_ready <= (w_occ_next <= 2'd1);
      if (w_pop) begin
        if (w_push) begin
          r_head <= in_payload;
        end else if (r_occ == 2'd2) begin
          r_head <= r_tail;
        end
      end else if (w_push) begin
        if (r_occ == 2'd0) begin
          r_head <= in_payload;
        end else begin
          r_tail <= in_payload;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : N-channel AXI-Stream round-robin arbiter. Grants one source
//                for a burst of up to BURST_LEN beats, tags each beat with the
//                source ID and drives the output through a skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int ID_WIDTH   = $clog2(NUM_CH),
  parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic [NUM_CH-1:0]            cfg_enable,
  input  logic [NUM_CH-1:0]            s_axis_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_CH-1:0]            s_axis_last,
  output logic [NUM_CH-1:0]            s_axis_ready,
  output logic                         m_axis_valid,
  output logic [DATA_WIDTH-1:0]        m_axis_data,
  output logic                         m_axis_last,
  output logic [ID_WIDTH-1:0]          m_axis_id,
  input  logic                         m_axis_ready,
  output logic                         busy
);

  localparam int c_pay_w = DATA_WIDTH + ID_WIDTH + 1;

  arb_state_t            r_state;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic [NUM_CH-1:0]     w_req;
  logic [ID_WIDTH-1:0]   w_winner;
  logic                  w_grant_valid;
  logic                  w_grant_last;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic                  w_skid_in_ready;
  logic                  w_fire;
  logic                  w_last_out;
  logic [c_pay_w-1:0]    w_in_payload;
  logic [c_pay_w-1:0]    w_out_payload;

  assign w_req         = s_axis_valid & cfg_enable;
  assign w_winner      = ID_WIDTH'(next_rr(c_max_ch'(w_req), 4'(r_last_grant), NUM_CH));
  assign w_grant_valid = s_axis_valid[r_grant];
  assign w_grant_last  = s_axis_last[r_grant];
  assign w_grant_data  = s_axis_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_fire        = (r_state == c_st_stream) & w_grant_valid & w_skid_in_ready;
  assign w_last_out    = w_grant_last | (r_beat_cnt == CNT_WIDTH'(BURST_LEN - 1));
  assign w_in_payload  = {w_grant_data, r_grant, w_last_out};
  assign busy          = (r_state == c_st_stream) | m_axis_valid;

  // Only the granted channel sees ready, and only from registered state
  always_comb begin
    s_axis_ready = '0;
    if (r_state == c_st_stream) begin
      s_axis_ready[r_grant] = w_skid_in_ready;
    end
  end

  // Arbitration FSM: one IDLE cycle per grant, burst ends on last/limit/valid drop
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= c_st_idle;
      r_grant      <= '0;
      r_last_grant <= ID_WIDTH'(NUM_CH - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|w_req) begin
            r_grant    <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= c_st_stream;
          end
        end
        default: begin
          if (!w_grant_valid) begin
            r_state      <= c_st_idle;
            r_last_grant <= r_grant;
          end else if (w_fire) begin
            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            if (w_last_out) begin
              r_state      <= c_st_idle;
              r_last_grant <= r_grant;
            end
          end
        end
      endcase
    end
  end

  axis_skid_buffer #(
    .PAYLOAD_WIDTH (c_pay_w)
  ) u_skid (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .in_valid    (w_fire),
    .in_ready    (w_skid_in_ready),
    .in_payload  (w_in_payload),
    .out_valid   (m_axis_valid),
    .out_ready   (m_axis_ready),
    .out_payload (w_out_payload)
  );

  assign {m_axis_data, m_axis_id, m_axis_last} = w_out_payload;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_rr_arbiter
//  Description : Scoreboard bench for axis_rr_arbiter. A transaction-level
//                reference decides grants and acceptances and queues expected
//                output beats; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int BL  = 16;

  logic              axi_clk = 1'b0;
  logic              axi_reset;
  logic [NCH-1:0]    cfg_enable;
  logic [NCH-1:0]    s_axis_valid;
  logic [NCH*DW-1:0] s_axis_data;
  logic [NCH-1:0]    s_axis_last;
  logic [NCH-1:0]    s_axis_ready;
  logic              m_axis_valid;
  logic [DW-1:0]     m_axis_data;
  logic              m_axis_last;
  logic [1:0]        m_axis_id;
  logic              m_axis_ready;
  logic              busy;

  axis_rr_arbiter #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .cfg_enable   (cfg_enable),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_id    (m_axis_id),
    .m_axis_ready (m_axis_ready),
    .busy         (busy)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [DW-1:0] d;
    int            id;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pops   = 0;

  // Reference: owner < 0 means arbitrating; buffer modelled by its fill level
  int    ref_owner;
  int    ref_prev;
  int    ref_beats;
  int    ref_fill;
  bit    ref_room;

  logic [DW-1:0] src_data [NCH];
  bit            src_last [NCH];
  bit            accepted [NCH];
  int            src_sent [NCH];
  logic [NCH-1:0] rnd_en;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ref_reset();
    ref_owner = -1;
    ref_prev  = NCH - 1;
    ref_beats = 0;
    ref_fill  = 0;
    ref_room  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) begin
      accepted[i] = 1'b0;
      src_sent[i] = 0;
    end
  endtask

  // Predict what the coming clock edge does with the inputs now applied
  task automatic ref_step();
    bit drain;
    bit took;
    bit lst;
    drain = (ref_fill > 0) && m_axis_ready;
    took  = 1'b0;
    if (ref_owner < 0) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (ref_prev + k) % NCH;
        if (ref_owner < 0 && s_axis_valid[c] && cfg_enable[c]) begin
          ref_owner = c;
          ref_beats = 0;
        end
      end
    end else if (!s_axis_valid[ref_owner]) begin
      ref_prev  = ref_owner;
      ref_owner = -1;
    end else if (ref_room) begin
      ref_beats++;
      lst = s_axis_last[ref_owner] || (ref_beats == BL);
      exp_q.push_back('{d: src_data[ref_owner], id: ref_owner, last: lst});
      accepted[ref_owner] = 1'b1;
      took = 1'b1;
      if (lst) begin
        ref_prev  = ref_owner;
        ref_owner = -1;
      end
    end
    ref_fill = ref_fill + int'(took) - int'(drain);
    ref_room = (ref_fill <= 1);
  endtask

  task automatic drive_sources(input int mode, input int cyc);
    logic [NCH-1:0] v;
    logic [NCH-1:0] l;
    logic [NCH-1:0] en;
    logic           mr;
    for (int i = 0; i < NCH; i++) begin
      if (accepted[i]) begin
        accepted[i] = 1'b0;
        src_sent[i]++;
        src_data[i] = $urandom;
        src_last[i] = ($urandom_range(0, 4) == 0);
      end
    end
    v  = s_axis_valid;
    l  = '0;
    en = '1;
    mr = 1'b1;
    case (mode)
      0: v = '1;
      1: begin
        v    = 4'b0100;
        l[2] = (src_sent[2] % 3 == 2);
      end
      2: begin
        v  = 4'b0010;
        mr = !(cyc >= 8 && cyc < 18);
      end
      3: begin
        v  = '1;
        en = (cyc < 44) ? 4'b1010 : 4'b1000;
      end
      4: begin
        v    = '0;
        v[0] = (src_sent[0] < 5);
        v[1] = 1'b1;
      end
      5: begin
        for (int i = 0; i < NCH; i++) begin
          if (v[i]) v[i] = ($urandom_range(0, 19) != 0);
          else      v[i] = ($urandom_range(0, 9) < 6);
          l[i] = src_last[i];
        end
        if (cyc % 50 == 0) rnd_en = 4'($urandom);
        en = rnd_en;
        mr = ($urandom_range(0, 3) != 0);
      end
      7: begin
        v  = 4'b0010;
        mr = 1'b0;
      end
      default: v = '0;
    endcase
    s_axis_valid = v;
    s_axis_last  = l;
    cfg_enable   = en;
    m_axis_ready = mr;
    for (int i = 0; i < NCH; i++) s_axis_data[i*DW +: DW] = src_data[i];
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < NCH; i++) src_sent[i] = 0;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(posedge axi_clk);
      #1;
      check("s_axis_ready", s_axis_ready,
            (ref_owner >= 0 && ref_room) ? (1 << ref_owner) : 0);
      check("m_axis_valid", m_axis_valid, ref_fill != 0);
      check("busy", busy, (ref_owner >= 0) || (ref_fill != 0));
      drive_sources(mode, cyc);
      ref_step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_axis_ready, 0);
    check({tag, "_m_valid"}, m_axis_valid, 0);
    check({tag, "_m_data"},  m_axis_data, 0);
    check({tag, "_m_last"},  m_axis_last, 0);
    check({tag, "_m_id"},    m_axis_id, 0);
    check({tag, "_busy"},    busy, 0);
  endtask

  // Monitor: every output handshake must match the oldest expected beat
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge axi_clk);
      if (!axi_reset && m_axis_valid && m_axis_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          pops++;
          check("out_data", m_axis_data, b.d);
          check("out_id", m_axis_id, b.id);
          check("out_last", m_axis_last, b.last);
        end
      end
    end
  end

  initial begin : stim
    axi_reset    = 1'b1;
    cfg_enable   = '0;
    s_axis_valid = '0;
    s_axis_last  = '0;
    s_axis_data  = '0;
    m_axis_ready = 1'b1;
    rnd_en       = '1;
    for (int i = 0; i < NCH; i++) begin
      src_data[i] = $urandom;
      src_last[i] = 1'b0;
    end
    ref_reset();
    repeat (3) @(posedge axi_clk);
    #1;
    check_reset_outputs("reset");
    axi_reset = 1'b0;

    run(0, 90);     // all channels, full bursts, round-robin order
    run(6, 10);
    run(1, 30);     // ch2 alone, last on every 3rd beat
    run(6, 10);
    run(2, 40);     // ch1 with a 10-cycle downstream stall
    run(6, 10);
    run(3, 90);     // enables 1010, then ch1 disabled mid-burst
    run(6, 10);
    run(5, 2000);   // randomized traffic
    run(6, 10);

    // Fill the buffer with ch1 beats, then reset mid-burst
    run(7, 8);
    #2;
    axi_reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    s_axis_valid = '0;
    ref_reset();
    @(posedge axi_clk);
    @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;

    run(4, 30);     // ch0 gives up after 5 beats, ch1 follows
    run(6, 20);

    check("drain_empty", exp_q.size(), 0);
    check("beats_seen", pops > 200, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
